// File: rtl/ntt_layer_ctrl_if.sv
// Bus between the NTT layer sequencer and its coefficient RAM, zeta ROM and butterfly.
// The master side is the sequencer; the slave side is the memory/butterfly environment.
interface ntt_layer_ctrl_if #(
  parameter int WID = 12
);
  logic           start;
  logic           mode;
  logic           busy;
  logic           done;
  logic [7:0]     ra0;
  logic [7:0]     ra1;
  logic [WID-1:0] rd0;
  logic [WID-1:0] rd1;
  logic [6:0]     zeta_idx;
  logic [WID-1:0] zeta;
  logic           we;
  logic [7:0]     wa0;
  logic [7:0]     wa1;
  logic [WID-1:0] wd0;
  logic [WID-1:0] wd1;
  logic [WID-1:0] bf_u;
  logic [WID-1:0] bf_t;
  logic [WID-1:0] bf_w;
  logic           bf_sel;
  logic [WID-1:0] bf_s0;
  logic [WID-1:0] bf_s1;

  modport master (
    input  start, mode, rd0, rd1, zeta, bf_s0, bf_s1,
    output busy, done, ra0, ra1, zeta_idx, we, wa0, wa1, wd0, wd1,
           bf_u, bf_t, bf_w, bf_sel
  );

  modport slave (
    output start, mode, rd0, rd1, zeta, bf_s0, bf_s1,
    input  busy, done, ra0, ra1, zeta_idx, we, wa0, wa1, wd0, wd1,
           bf_u, bf_t, bf_w, bf_sel
  );
endinterface

// File: rtl/ntt_layer_ctrl.sv
// Sequences a 256-point Kyber NTT/INTT (7 layers x 128 butterflies) over a shared
// butterfly: issues pair reads, forwards operands, writes results back in place.
module ntt_layer_ctrl #(
  parameter int WID    = 12,
  parameter int BF_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  ntt_layer_ctrl_if.master  bus
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

  state_t      r_state;
  logic        r_mode;
  logic        r_busy;
  logic        r_done;
  logic [2:0]  r_layer;
  logic [6:0]  r_p;
  logic [BF_LAT:0] r_vld_p;
  logic [7:0]  r_wa0_p [0:BF_LAT];
  logic [7:0]  r_wa1_p [0:BF_LAT];

  logic        w_issue;
  logic [2:0]  w_l;
  logic [7:0]  w_len;
  logic [7:0]  w_j;
  logic [7:0]  w_ra0;
  logic [7:0]  w_ra1;
  logic [6:0]  w_zidx;
  logic        w_we;

  // log2 of the butterfly span: NTT shrinks 128..2, INTT grows 2..128
  function automatic logic [2:0] log_len(input logic mode, input logic [2:0] layer);
    return mode ? (3'd7 - layer) : (layer + 3'd1);
  endfunction

  function automatic logic [7:0] pair_j(input logic [6:0] p, input logic [2:0] l);
    logic [7:0] len;
    logic [7:0] g;
    logic [7:0] off;
    len = 8'd1 << l;
    g   = {1'b0, p} >> l;
    off = {1'b0, p} & (len - 8'd1);
    return (g << ({1'b0, l} + 4'd1)) + off;
  endfunction

  function automatic logic [6:0] zeta_index(input logic mode, input logic [6:0] p,
                                            input logic [2:0] l);
    logic [7:0] g;
    logic [7:0] z;
    g = {1'b0, p} >> l;
    if (mode) z = (8'd1 << (3'd7 - l)) + g;
    else      z = (8'd1 << (4'd8 - {1'b0, l})) - 8'd1 - g;
    return z[6:0];
  endfunction

  assign w_issue = (r_state == S_ISSUE);
  assign w_l     = log_len(r_mode, r_layer);
  assign w_len   = 8'd1 << w_l;
  assign w_j     = pair_j(r_p, w_l);
  assign w_ra0   = w_issue ? w_j : 8'd0;
  assign w_ra1   = w_issue ? (w_j + w_len) : 8'd0;
  assign w_zidx  = w_issue ? zeta_index(r_mode, r_p, w_l) : 7'd0;
  assign w_we    = r_vld_p[BF_LAT];

  assign bus.ra0      = w_ra0;
  assign bus.ra1      = w_ra1;
  assign bus.zeta_idx = w_zidx;
  assign bus.busy     = r_busy;
  assign bus.done     = r_done;
  assign bus.bf_sel   = r_mode;

  // Stage p0: read data / zeta arrive one cycle after issue and go straight to the butterfly
  assign bus.bf_u = r_vld_p[0] ? bus.rd0  : '0;
  assign bus.bf_t = r_vld_p[0] ? bus.rd1  : '0;
  assign bus.bf_w = r_vld_p[0] ? bus.zeta : '0;

  // Stage p(BF_LAT): butterfly results written back to the addresses they were read from
  assign bus.we  = w_we;
  assign bus.wa0 = w_we ? r_wa0_p[BF_LAT] : 8'd0;
  assign bus.wa1 = w_we ? r_wa1_p[BF_LAT] : 8'd0;
  assign bus.wd0 = w_we ? bus.bf_s0 : '0;
  assign bus.wd1 = w_we ? bus.bf_s1 : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_mode  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_layer <= 3'd0;
      r_p     <= 7'd0;
      r_vld_p <= '0;
    end else begin
      r_done  <= 1'b0;
      r_vld_p <= {r_vld_p[BF_LAT-1:0], w_issue};
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_mode  <= bus.mode;
            r_layer <= 3'd0;
            r_p     <= 7'd0;
            r_busy  <= 1'b1;
            r_state <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          r_p <= r_p + 7'd1;
          if (r_p == 7'd127) r_state <= S_DRAIN;
        end
        S_DRAIN: begin
          // The write retiring this cycle is the layer's last one, so the next read is safe
          if (r_vld_p[BF_LAT-1:0] == '0) begin
            if (r_layer < 3'd6) begin
              r_layer <= r_layer + 3'd1;
              r_p     <= 7'd0;
              r_state <= S_ISSUE;
            end else begin
              r_done  <= 1'b1;
              r_busy  <= 1'b0;
              r_state <= S_DONE;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Address tags travel beside vld_p; they are only observed when the matching valid is set
  always_ff @(posedge clk) begin
    r_wa0_p[0] <= w_ra0;
    r_wa1_p[0] <= w_ra1;
    for (int k = 1; k <= BF_LAT; k++) begin
      r_wa0_p[k] <= r_wa0_p[k-1];
      r_wa1_p[k] <= r_wa1_p[k-1];
    end
  end

endmodule

// File: tb/tb_ntt_layer_ctrl.sv
// Directed bench for ntt_layer_ctrl with a RAM/ROM model and a reference Kyber butterfly.
module tb_ntt_layer_ctrl;
  localparam int WID    = 12;
  localparam int BF_LAT = 2;
  localparam int Q      = 3329;
  localparam int LAYER_CYC = 128 + 1 + BF_LAT;
  localparam int RUN    = 7 * LAYER_CYC;
  localparam int MAXC   = 1000;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  ntt_layer_ctrl_if #(.WID(WID)) bus ();
  ntt_layer_ctrl #(.WID(WID), .BF_LAT(BF_LAT)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_cmp = 0;
  int n_err = 0;

  logic [11:0] ram [256];
  logic [11:0] img [256];
  logic        load;
  int          zt [128];
  int          orig_a [256];
  int          ref_a [256];

  // Memory environment: registered reads, write port, bulk preload
  always @(posedge clk) begin
    bus.rd0  <= ram[bus.ra0];
    bus.rd1  <= ram[bus.ra1];
    bus.zeta <= 12'(zt[bus.zeta_idx]);
    if (load) begin
      for (int i = 0; i < 256; i++) ram[i] <= img[i];
    end else if (bus.we) begin
      ram[bus.wa0] <= bus.wd0;
      ram[bus.wa1] <= bus.wd1;
    end
  end

  function automatic logic [11:0] bfs0(input int u, input int t, input int w, input logic sel);
    if (sel) return 12'((u + (w * t) % Q) % Q);
    return 12'((u + t) % Q);
  endfunction

  function automatic logic [11:0] bfs1(input int u, input int t, input int w, input logic sel);
    if (sel) return 12'((u - (w * t) % Q + Q) % Q);
    return 12'((w * ((t - u + Q) % Q)) % Q);
  endfunction

  // Reference butterfly with a two-register pipeline
  logic [11:0] s0_p1, s1_p1;
  always @(posedge clk) begin
    s0_p1     <= bfs0(int'(bus.bf_u), int'(bus.bf_t), int'(bus.bf_w), bus.bf_sel);
    s1_p1     <= bfs1(int'(bus.bf_u), int'(bus.bf_t), int'(bus.bf_w), bus.bf_sel);
    bus.bf_s0 <= s0_p1;
    bus.bf_s1 <= s1_p1;
  end

  int ra0_l [MAXC];
  int ra1_l [MAXC];
  int z_l   [MAXC];
  int wa0_l [MAXC];
  int wa1_l [MAXC];
  bit we_l  [MAXC];
  bit sel_l [MAXC];
  bit busy_l[MAXC];
  int done_cyc;

  task automatic load_ram();
    for (int i = 0; i < 256; i++) img[i] = 12'(orig_a[i]);
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  // Kyber forward NTT, textbook loop order, normal-domain zetas
  task automatic sw_ntt();
    int k, z, t;
    k = 1;
    for (int len = 128; len >= 2; len = len >> 1) begin
      for (int s = 0; s < 256; s = s + 2 * len) begin
        z = zt[k];
        k++;
        for (int j = s; j < s + len; j++) begin
          t = (z * ref_a[j + len]) % Q;
          ref_a[j + len] = (ref_a[j] - t + Q) % Q;
          ref_a[j] = (ref_a[j] + t) % Q;
        end
      end
    end
  endtask

  // Starts a run, logs every cycle after the accept edge (index 0) until done or budget
  task automatic run_op(input logic m, input int pulse_at);
    done_cyc = -1;
    @(negedge clk);
    bus.mode  = m;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.mode  = ~m;
    for (int k = 0; k < MAXC; k++) begin
      ra0_l[k]  = int'(bus.ra0);
      ra1_l[k]  = int'(bus.ra1);
      z_l[k]    = int'(bus.zeta_idx);
      wa0_l[k]  = int'(bus.wa0);
      wa1_l[k]  = int'(bus.wa1);
      we_l[k]   = bus.we;
      sel_l[k]  = bus.bf_sel;
      busy_l[k] = bus.busy;
      bus.start = (k == pulse_at);
      if (bus.done) begin
        done_cyc = k;
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  function automatic int we_total();
    int n = 0;
    for (int k = 0; k <= done_cyc; k++) if (we_l[k]) n++;
    return n;
  endfunction

  function automatic int we_pattern_errs();
    int e = 0;
    for (int k = 0; k <= done_cyc; k++)
      if (we_l[k] != ((k % LAYER_CYC) >= 1 + BF_LAT && k < RUN)) e++;
    return e;
  endfunction

  function automatic int write_tag_errs();
    int e = 0;
    for (int k = 0; k <= done_cyc; k++) begin
      if (we_l[k]) begin
        if (k < 1 + BF_LAT) e++;
        else if (wa0_l[k] != ra0_l[k-1-BF_LAT] || wa1_l[k] != ra1_l[k-1-BF_LAT]) e++;
      end
    end
    return e;
  endfunction

  function automatic int sel_errs(input logic m);
    int e = 0;
    for (int k = 0; k <= done_cyc; k++) if (sel_l[k] !== m) e++;
    return e;
  endfunction

  task automatic test_reset();
    int e;
    logic [63:0] v;
    repeat (3) @(negedge clk);
    v = {bus.busy, bus.done, bus.we, bus.ra0, bus.ra1, bus.zeta_idx, bus.wa0, bus.wa1,
         bus.wd0, bus.wd1, bus.bf_sel};
    n_cmp++;
    if (v !== 64'd0) begin
      n_err++;
      $display("FAIL reset_outputs: got %h required 0", v);
    end
    rst = 1'b1;
    e = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.we !== 1'b0 || bus.ra0 !== 8'd0 ||
          bus.ra1 !== 8'd0 || bus.zeta_idx !== 7'd0) e++;
    end
    n_cmp++;
    if (e !== 0) begin
      n_err++;
      $display("FAIL idle_100: %0d busy/active cycles, required 0", e);
    end
  endtask

  task automatic test_ntt();
    int e;
    for (int i = 0; i < 256; i++) begin
      orig_a[i] = int'($urandom_range(Q - 1, 0));
      ref_a[i]  = orig_a[i];
    end
    load_ram();
    run_op(1'b1, -1);
    n_cmp++;
    if (done_cyc !== RUN) begin
      n_err++;
      $display("FAIL ntt_done_cycle: got %0d required %0d", done_cyc, RUN);
    end
    n_cmp++;
    if (busy_l[0] !== 1'b1) begin
      n_err++;
      $display("FAIL ntt_busy_start: got %0d required 1", busy_l[0]);
    end
    n_cmp++;
    if (ra0_l[0] !== 0 || ra1_l[0] !== 128 || z_l[0] !== 1) begin
      n_err++;
      $display("FAIL ntt_first_issue: got %0d/%0d/%0d required 0/128/1", ra0_l[0], ra1_l[0], z_l[0]);
    end
    n_cmp++;
    if (ra0_l[195] !== 128 || ra1_l[195] !== 192 || z_l[195] !== 3) begin
      n_err++;
      $display("FAIL ntt_layer1_p64: got %0d/%0d/%0d required 128/192/3", ra0_l[195], ra1_l[195], z_l[195]);
    end
    n_cmp++;
    if (ra0_l[913] !== 253 || ra1_l[913] !== 255 || z_l[913] !== 127) begin
      n_err++;
      $display("FAIL ntt_last_issue: got %0d/%0d/%0d required 253/255/127", ra0_l[913], ra1_l[913], z_l[913]);
    end
    n_cmp++;
    if (we_total() !== 896) begin
      n_err++;
      $display("FAIL ntt_we_count: got %0d required 896", we_total());
    end
    n_cmp++;
    if (we_pattern_errs() !== 0) begin
      n_err++;
      $display("FAIL ntt_we_pattern: %0d wrong cycles, required 0", we_pattern_errs());
    end
    n_cmp++;
    if (write_tag_errs() !== 0) begin
      n_err++;
      $display("FAIL ntt_write_tag: %0d writes mistagged, required 0", write_tag_errs());
    end
    n_cmp++;
    if (sel_errs(1'b1) !== 0) begin
      n_err++;
      $display("FAIL ntt_sel: %0d cycles with bf_sel!=1, required 0", sel_errs(1'b1));
    end
    sw_ntt();
    e = 0;
    for (int i = 0; i < 256; i++) begin
      n_cmp++;
      if (int'(ram[i]) !== ref_a[i]) begin
        n_err++;
        $display("FAIL ntt_coef[%0d]: got %0d required %0d", i, ram[i], ref_a[i]);
      end
    end
  endtask

  task automatic test_intt();
    run_op(1'b0, -1);
    n_cmp++;
    if (done_cyc !== RUN) begin
      n_err++;
      $display("FAIL intt_done_cycle: got %0d required %0d", done_cyc, RUN);
    end
    n_cmp++;
    if (ra0_l[0] !== 0 || ra1_l[0] !== 2 || z_l[0] !== 127) begin
      n_err++;
      $display("FAIL intt_first_issue: got %0d/%0d/%0d required 0/2/127", ra0_l[0], ra1_l[0], z_l[0]);
    end
    n_cmp++;
    if (ra0_l[913] !== 127 || ra1_l[913] !== 255 || z_l[913] !== 1) begin
      n_err++;
      $display("FAIL intt_last_issue: got %0d/%0d/%0d required 127/255/1", ra0_l[913], ra1_l[913], z_l[913]);
    end
    n_cmp++;
    if (sel_errs(1'b0) !== 0) begin
      n_err++;
      $display("FAIL intt_sel: %0d cycles with bf_sel!=0, required 0", sel_errs(1'b0));
    end
    n_cmp++;
    if (write_tag_errs() !== 0 || we_total() !== 896) begin
      n_err++;
      $display("FAIL intt_writes: tag errs %0d count %0d, required 0 and 896", write_tag_errs(), we_total());
    end
    for (int i = 0; i < 256; i++) begin
      n_cmp++;
      if (int'(ram[i]) !== (128 * orig_a[i]) % Q) begin
        n_err++;
        $display("FAIL roundtrip_coef[%0d]: got %0d required %0d", i, ram[i], (128 * orig_a[i]) % Q);
      end
    end
  endtask

  task automatic test_start_while_busy();
    run_op(1'b1, 300);
    n_cmp++;
    if (done_cyc !== RUN) begin
      n_err++;
      $display("FAIL busy_start_done: got %0d required %0d", done_cyc, RUN);
    end
    n_cmp++;
    if (sel_errs(1'b1) !== 0 || we_total() !== 896) begin
      n_err++;
      $display("FAIL busy_start_mode: sel errs %0d writes %0d, required 0 and 896", sel_errs(1'b1), we_total());
    end
  endtask

  task automatic test_start_at_done();
    run_op(1'b0, RUN);
    n_cmp++;
    if (done_cyc !== RUN) begin
      n_err++;
      $display("FAIL done_start_done: got %0d required %0d", done_cyc, RUN);
    end
    n_cmp++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      n_err++;
      $display("FAIL done_start_ignored: busy=%0d done=%0d required 0/0", bus.busy, bus.done);
    end
    @(negedge clk);
    n_cmp++;
    if (bus.busy !== 1'b0) begin
      n_err++;
      $display("FAIL done_start_idle: busy=%0d required 0", bus.busy);
    end
  endtask

  task automatic test_rst_midrun();
    @(negedge clk);
    bus.mode  = 1'b1;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3 * LAYER_CYC + 50) @(negedge clk);
    n_cmp++;
    if (bus.we !== 1'b1 || bus.busy !== 1'b1) begin
      n_err++;
      $display("FAIL rst_pre_active: we=%0d busy=%0d required 1/1", bus.we, bus.busy);
    end
    rst = 1'b0;
    #1;
    n_cmp++;
    if (bus.we !== 1'b0 || bus.busy !== 1'b0 || bus.ra0 !== 8'd0 || bus.ra1 !== 8'd0) begin
      n_err++;
      $display("FAIL rst_immediate: we=%0d busy=%0d ra0=%0d ra1=%0d required 0", bus.we, bus.busy, bus.ra0, bus.ra1);
    end
    @(negedge clk);
    @(negedge clk);
    n_cmp++;
    if (bus.we !== 1'b0 || bus.busy !== 1'b0) begin
      n_err++;
      $display("FAIL rst_held: we=%0d busy=%0d required 0/0", bus.we, bus.busy);
    end
    rst = 1'b1;
    run_op(1'b1, -1);
    n_cmp++;
    if (done_cyc !== RUN || we_total() !== 896) begin
      n_err++;
      $display("FAIL rst_rerun: done %0d writes %0d required %0d/896", done_cyc, we_total(), RUN);
    end
    n_cmp++;
    if (ra0_l[0] !== 0 || ra1_l[0] !== 128 || z_l[0] !== 1) begin
      n_err++;
      $display("FAIL rst_rerun_first: got %0d/%0d/%0d required 0/128/1", ra0_l[0], ra1_l[0], z_l[0]);
    end
  endtask

  initial begin
    int br, z;
    bus.start = 1'b0;
    bus.mode  = 1'b0;
    load      = 1'b0;
    for (int i = 0; i < 128; i++) begin
      br = 0;
      for (int b = 0; b < 7; b++) if (((i >> b) & 1) == 1) br = br | (1 << (6 - b));
      z = 1;
      for (int e = 0; e < br; e++) z = (z * 17) % Q;
      zt[i] = z;
    end
    for (int i = 0; i < 256; i++) img[i] = 12'd0;
    test_reset();
    test_ntt();
    test_intt();
    test_start_while_busy();
    test_start_at_done();
    test_rst_midrun();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ntt_layer_ctrl.md
Name: ntt_layer_ctrl

Overview:
- Sequencer that drives the shared 12-bit Kyber butterfly through a full 256-point NTT or INTT: 7 layers of 128 butterflies each.
- Reads coefficient pairs from a dual-port coefficient RAM and the matching twiddle from the zeta ROM, and presents them to the butterfly as u/t/w with sel.
- Captures s0/s1 after the butterfly latency and writes them back in place.
- Sits between the polynomial RAM and the butterfly. It is the issuing/collecting end of the butterfly interface.

Parameters:
- WID, 12, coefficient width.
- BF_LAT, 2, butterfly latency in cycles from u/t/w valid to s0/s1 valid (fixed, fully pipelined).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- mode  in  1  1 = NTT, 0 = INTT; latched on accepted start.
- busy  out  1  high from accepted start until done.
- done  out  1  one-cycle pulse at completion.
- ra0, ra1  out  8  RAM read addresses (j, j+len).
- rd0, rd1  in  WID  RAM read data, valid 1 cycle after address.
- zeta_idx  out  7  zeta ROM address; data valid 1 cycle later.
- zeta  in  WID  ROM data.
- we  out  1  RAM write enable (both ports).
- wa0, wa1  out  8  RAM write addresses.
- wd0, wd1  out  WID  RAM write data.
- bf_u, bf_t, bf_w  out  WID  butterfly operands: combinational from rd0, rd1, zeta.
- bf_sel  out  1  butterfly mode, equal to the latched mode.
- bf_s0, bf_s1  in  WID  butterfly results.

Behaviour:
- Reset values: busy=0, done=0, we=0, all address/data outputs 0, bf_sel=0, state IDLE, all counters 0, valid pipe cleared.
- FSM:
  - IDLE -> ISSUE on start; latch mode, layer=0, p=0.
  - ISSUE: one pair per cycle, p 0..127. After p=127 -> DRAIN.
  - DRAIN: wait until the in-flight valid pipe is empty. If layer<6: layer+1, p=0, -> ISSUE. Else -> DONE.
  - DONE: done=1 for one cycle, busy=0 -> IDLE.
- Layer length:
  - NTT: len = 128 >> layer (128..2).
  - INTT: len = 2 << layer (2..128).
  - l = log2(len).
- Pair addressing: g = p >> l, off = p & (len-1), j = 2*len*g + off. ra0 = j, ra1 = j+len.
- Twiddle index:
  - NTT: zeta_idx = 128/len + g.
  - INTT: zeta_idx = 256/len - 1 - g.
  - zeta_idx is driven in the same cycle as ra0/ra1.
- Pipeline:
  - Issue cycle c: addresses driven.
  - Cycle c+1: rd/zeta valid and forwarded to bf_u/bf_t/bf_w.
  - Cycle c+1+BF_LAT: we=1, wa0/wa1 = issue addresses (carried in a (1+BF_LAT)-deep shift register with a valid bit), wd0 = bf_s0, wd1 = bf_s1.
- Hazard rule:
  - Pairs within a layer are disjoint, so back-to-back issue is allowed.
  - The next layer never reads before the last write of the previous layer. DRAIN enforces this.
- Cycle budget: each layer costs 128 + 1 + BF_LAT cycles (ISSUE plus DRAIN). With BF_LAT=2: done pulses 917 cycles after the start-accept edge. Exactly 896 write cycles total.
- Out of scope: final INTT n^-1 scaling (done by the butterfly or downstream).
- start while busy: ignored, no restart, mode unchanged.
- start in the same cycle as done: ignored. Accepted only from IDLE, the following cycle.
- rst asserted mid-operation:
  - Immediate return to reset values. we drops asynchronously and no further writes occur.
  - RAM contents are left partially transformed. A new start restarts from layer 0.
- No stall input: RAM, ROM and butterfly are assumed always ready.

Test Plan:
- Reset: hold rst=0 with clock running -> busy=0, done=0, we=0, all addresses 0. Release, no start -> outputs stay idle for 100 cycles.
- NTT address trace (mode=1):
  - First issue: ra0=0, ra1=128, zeta_idx=1.
  - Layer 1, p=64: ra0=128, ra1=192, zeta_idx=3.
  - Last issue of layer 6: ra0=253, ra1=255, zeta_idx=127.
  - done at cycle 917, we high exactly 896 cycles.
- INTT address trace (mode=0):
  - First issue: ra0=0, ra1=2, zeta_idx=127.
  - Last issue: ra0=127, ra1=255, zeta_idx=1.
  - bf_sel=0 throughout.
- Functional: RAM model plus reference butterfly and zeta table. Random polynomial -> NTT result matches software Kyber NTT. Running NTT then INTT returns the input times the INTT scaling constant.
- Write timing: tag each write against the issue cycle -> wa0/wa1 equal the addresses issued exactly 1+BF_LAT cycles earlier. No read of layer L+1 before the last write of layer L.
- Disturbances:
  - start pulsed at cycle 300 of a run -> ignored, done still at cycle 917.
  - rst asserted during layer 3 -> we=0 and busy=0 immediately. A subsequent start produces the full 917-cycle run starting at ra0=0.
